// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths, command kinds, FSM states and the
// latched command payload used by the memory arbiter and its priority
// select.
package mem_arbiter_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned INST_OP_WIDTH  = 6;
  localparam int unsigned ROB_SIZE_WIDTH = 4;
  localparam int unsigned MEM_KIND_WIDTH = 2;

  // Default value of addr[17:16] that selects the IO-mapped region.
  localparam logic [1:0] IO_ADDR_SEL = 2'b11;

  // One-hot grant vector positions.
  localparam int unsigned NUM_REQ    = 3;
  localparam int unsigned GNT_ICACHE = 0;
  localparam int unsigned GNT_LSB    = 1;
  localparam int unsigned GNT_ROB    = 2;

  typedef enum logic [MEM_KIND_WIDTH-1:0] {
    MEM_KIND_INST  = 2'd0,
    MEM_KIND_LOAD  = 2'd1,
    MEM_KIND_STORE = 2'd2
  } mem_kind_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } arb_state_e;

  typedef struct packed {
    mem_kind_e                 kind;
    logic [INST_OP_WIDTH-1:0]  op;
    logic [XLEN-1:0]           addr;
    logic [XLEN-1:0]           val;
    logic [ROB_SIZE_WIDTH-1:0] id;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_prio.sv
// mem_arb_prio: combinational eligibility filter and fixed-priority select.
// Ports:
//   icache_req, lsb_req, rob_req  raw request levels
//   flush                         blocks loads and fetches
//   io_stall                      store targets IO while the UART buffer is full
//   age_hit                       fetch has aged out; it outranks everything
//   grant                         one-hot winner (GNT_* positions), '0 if none
module mem_arb_prio
  import mem_arbiter_pkg::*;
(
  input  logic               icache_req,
  input  logic               lsb_req,
  input  logic               rob_req,
  input  logic               flush,
  input  logic               io_stall,
  input  logic               age_hit,
  output logic [NUM_REQ-1:0] grant
);

  logic fetch_ok;
  logic load_ok;
  logic store_ok;

  always_comb begin
    fetch_ok = icache_req && !flush;
    load_ok  = lsb_req && !flush;
    store_ok = rob_req && !io_stall;
    grant    = '0;
    if (age_hit && fetch_ok) begin
      grant[GNT_ICACHE] = 1'b1;
    end else if (store_ok) begin
      grant[GNT_ROB] = 1'b1;
    end else if (load_ok) begin
      grant[GNT_LSB] = 1'b1;
    end else if (fetch_ok) begin
      grant[GNT_ICACHE] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants one of fetch / load / store at a time to the
// byte-serial memory controller, issues it as a one-cycle command and waits
// for mem_done before granting again (back-to-back on the done cycle).
// Ports: clk, rst (sync, active-high), rdy (global hold), flush,
//   icache_*/lsb_*/rob_* requests with payloads, io_buffer_full, mem_done;
//   arb_*_ack grant pulses, arb_mem_valid strobe, arb_mem_* latched payload,
//   arb_busy (command in flight).
// Build option: define MEM_ARB_AGING_EN to enable the fetch aging counter
// that promotes a starved fetch to top priority after AGE_LIMIT cycles.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AGE_LIMIT  = 8,
  parameter logic [1:0]  IO_ADDR_HI = IO_ADDR_SEL
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      flush,
  input  logic                      icache_req,
  input  logic [XLEN-1:0]           icache_addr,
  input  logic                      lsb_req,
  input  logic [INST_OP_WIDTH-1:0]  lsb_op,
  input  logic [XLEN-1:0]           lsb_addr,
  input  logic [ROB_SIZE_WIDTH-1:0] lsb_id,
  input  logic                      rob_req,
  input  logic [INST_OP_WIDTH-1:0]  rob_op,
  input  logic [XLEN-1:0]           rob_addr,
  input  logic [XLEN-1:0]           rob_val,
  input  logic                      io_buffer_full,
  input  logic                      mem_done,
  output logic                      arb_icache_ack,
  output logic                      arb_lsb_ack,
  output logic                      arb_rob_ack,
  output logic                      arb_mem_valid,
  output logic [MEM_KIND_WIDTH-1:0] arb_mem_kind,
  output logic [INST_OP_WIDTH-1:0]  arb_mem_op,
  output logic [XLEN-1:0]           arb_mem_addr,
  output logic [XLEN-1:0]           arb_mem_val,
  output logic [ROB_SIZE_WIDTH-1:0] arb_mem_id,
  output logic                      arb_busy
);

  if (AGE_LIMIT > 15) begin : g_age_limit_chk
    $error("AGE_LIMIT must fit the 4-bit age counter");
  end

  arb_state_e         state_q, state_d;
  mem_cmd_t           cmd_q, cmd_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               valid_q, valid_d;
  logic [NUM_REQ-1:0] grant;
  logic               eval;
  logic               io_stall;
  logic               age_hit;

  assign io_stall = io_buffer_full && (rob_addr[17:16] == IO_ADDR_HI);

  // A new winner may be picked when idle, or on the done cycle of the
  // current command so the next command issues with no bubble.
  assign eval = (state_q == S_IDLE) || mem_done;

`ifdef MEM_ARB_AGING_EN
  logic [3:0] age_q, age_d;

  assign age_hit = (age_q == 4'(AGE_LIMIT));

  always_comb begin
    age_d = age_q;
    if (flush || (eval && grant[GNT_ICACHE])) begin
      age_d = '0;
    end else if (icache_req && !age_hit) begin
      age_d = age_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      age_q <= '0;
    end else if (rdy) begin
      age_q <= age_d;
    end
  end
`else
  assign age_hit = 1'b0;
`endif

  mem_arb_prio u_prio (
    .icache_req (icache_req),
    .lsb_req    (lsb_req),
    .rob_req    (rob_req),
    .flush      (flush),
    .io_stall   (io_stall),
    .age_hit    (age_hit),
    .grant      (grant)
  );

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    ack_d   = '0;
    valid_d = 1'b0;
    if (eval && (|grant)) begin
      state_d = S_WAIT;
      ack_d   = grant;
      valid_d = 1'b1;
      cmd_d   = '0;
      if (grant[GNT_ROB]) begin
        cmd_d.kind = MEM_KIND_STORE;
        cmd_d.op   = rob_op;
        cmd_d.addr = rob_addr;
        cmd_d.val  = rob_val;
      end else if (grant[GNT_LSB]) begin
        cmd_d.kind = MEM_KIND_LOAD;
        cmd_d.op   = lsb_op;
        cmd_d.addr = lsb_addr;
        cmd_d.id   = lsb_id;
      end else begin
        cmd_d.kind = MEM_KIND_INST;
        cmd_d.addr = icache_addr;
      end
    end else if (state_q == S_WAIT && mem_done) begin
      state_d = S_IDLE;
    end else if (state_q == S_WAIT && flush && cmd_q.kind != MEM_KIND_STORE) begin
      // Controller aborts the same load/fetch; any late done lands in IDLE.
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      ack_q   <= '0;
      valid_q <= 1'b0;
    end else if (rdy) begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
    end
  end

  assign arb_icache_ack = ack_q[GNT_ICACHE];
  assign arb_lsb_ack    = ack_q[GNT_LSB];
  assign arb_rob_ack    = ack_q[GNT_ROB];
  assign arb_mem_valid  = valid_q;
  assign arb_mem_kind   = cmd_q.kind;
  assign arb_mem_op     = cmd_q.op;
  assign arb_mem_addr   = cmd_q.addr;
  assign arb_mem_val    = cmd_q.val;
  assign arb_mem_id     = cmd_q.id;
  assign arb_busy       = (state_q == S_WAIT);

endmodule
